atmega_io_bus_master: RTL and testbench

- Command-driven initiator for the mega IO register bus (addr/wr/rd/bus_in/bus_out), the same bus atmega_pll and sibling peripherals respond on.
- Converts single-entry commands (write, read, poll-until-match) into correctly timed wr/rd strobes and returns one response per command.
- Used by boot/config sequencers and debug bridges, e.g. to program PLLFRQ and then wait for the PLOCK bit in PLLCSR.

---
 rtl/atmega_io_bus_master.sv | 198 +++++++++++++++++++
 tb/tb_atmega_io_bus_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atmega_io_bus_master.sv
// Command-driven initiator for the mega IO register bus: write, read and poll-until-match.
// Latency: write responds 2 cycles after accept; read/poll responds RD_LATENCY+3 cycles after accept per read.
// Backpressure: cmd_ready is high only in IDLE; one command in flight, one rsp_valid pulse per command.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_op 00 write, 01 read, 10 poll, 11 read
//   cmd_addr/data/mask       register address, write data or poll compare value, poll mask
//   rsp_valid/data/timeout   one-cycle response pulse; data and timeout flag hold until next response
//   io_addr/wr/rd/dout/din   peripheral bus (addr, wr, rd, bus_in, bus_out)
module atmega_io_bus_master #(
    parameter int BUS_ADDR_DATA_LEN = 6,
    parameter int RD_LATENCY        = 1,
    parameter int POLL_INTERVAL     = 4,
    parameter int POLL_TIMEOUT      = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [BUS_ADDR_DATA_LEN-1:0] cmd_addr,
    input  logic [7:0]                   cmd_data,
    input  logic [7:0]                   cmd_mask,
    output logic                         rsp_valid,
    output logic [7:0]                   rsp_data,
    output logic                         rsp_timeout,
    output logic [BUS_ADDR_DATA_LEN-1:0] io_addr,
    output logic                         io_wr,
    output logic                         io_rd,
    output logic [7:0]                   io_dout,
    input  logic [7:0]                   io_din
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_POLL  = 2'b10;

    // Terminal values for the shared wait counter; only used when the
    // corresponding length is non-zero, so the clamp to 0 is never observed.
    localparam logic [7:0]  RD_LAST     = 8'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
    localparam logic [7:0]  GAP_LAST    = 8'((POLL_INTERVAL > 0) ? POLL_INTERVAL - 1 : 0);
    localparam logic [15:0] TIMEOUT_CNT = 16'(POLL_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_WAIT,
        S_CMP,
        S_GAP,
        S_RESP
    } state_t;

    state_t                         state_q, state_d;
    logic [BUS_ADDR_DATA_LEN-1:0]   addr_q, addr_d;
    logic [7:0]                     dout_q, dout_d;      // write data and poll compare value
    logic [7:0]                     mask_q, mask_d;
    logic [1:0]                     op_q, op_d;
    logic [7:0]                     din_q, din_d;        // captured read data
    logic [7:0]                     wait_cnt_q, wait_cnt_d;
    logic [15:0]                    poll_cnt_q, poll_cnt_d;
    logic [7:0]                     rsp_data_q, rsp_data_d;
    logic                           rsp_to_q, rsp_to_d;

    logic [15:0]                    poll_cnt_inc;
    logic                           poll_match;

    assign poll_cnt_inc = poll_cnt_q + 16'd1;
    assign poll_match   = ((din_q & mask_q) == (dout_q & mask_q));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        mask_d     = mask_q;
        op_d       = op_q;
        din_d      = din_q;
        wait_cnt_d = wait_cnt_q;
        poll_cnt_d = poll_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_to_d   = rsp_to_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    dout_d     = cmd_data;
                    mask_d     = cmd_mask;
                    op_d       = cmd_op;
                    poll_cnt_d = 16'd0;
                    wait_cnt_d = 8'd0;
                    state_d    = (cmd_op == OP_WRITE) ? S_WR : S_RD;
                end
            end

            S_WR: begin
                rsp_data_d = 8'h00;
                rsp_to_d   = 1'b0;
                state_d    = S_RESP;
            end

            S_RD: begin
                // Zero-latency peripherals present data in the strobe cycle itself.
                if (RD_LATENCY == 0) begin
                    din_d   = io_din;
                    state_d = S_CMP;
                end else begin
                    wait_cnt_d = 8'd0;
                    state_d    = S_RD_WAIT;
                end
            end

            S_RD_WAIT: begin
                if (wait_cnt_q == RD_LAST) begin
                    din_d   = io_din;
                    state_d = S_CMP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            S_CMP: begin
                // Plain reads pass through CMP too, so read and poll share one timing.
                if (op_q != OP_POLL || poll_match) begin
                    rsp_data_d = din_q;
                    rsp_to_d   = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    poll_cnt_d = poll_cnt_inc;
                    if (poll_cnt_inc == TIMEOUT_CNT) begin
                        rsp_data_d = din_q;
                        rsp_to_d   = 1'b1;
                        state_d    = S_RESP;
                    end else if (POLL_INTERVAL == 0) begin
                        state_d = S_RD;
                    end else begin
                        wait_cnt_d = 8'd0;
                        state_d    = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (wait_cnt_q == GAP_LAST) begin
                    state_d = S_RD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            dout_q     <= 8'h00;
            mask_q     <= 8'h00;
            op_q       <= 2'b00;
            din_q      <= 8'h00;
            wait_cnt_q <= 8'd0;
            poll_cnt_q <= 16'd0;
            rsp_data_q <= 8'h00;
            rsp_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            mask_q     <= mask_d;
            op_q       <= op_d;
            din_q      <= din_d;
            wait_cnt_q <= wait_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_to_q   <= rsp_to_d;
        end
    end

    // Strobes decode straight from state, so each lasts exactly one state cycle
    // and a reset drops them in the cycle after it is sampled.
    assign cmd_ready   = (state_q == S_IDLE);
    assign io_wr       = (state_q == S_WR);
    assign io_rd       = (state_q == S_RD);
    assign rsp_valid   = (state_q == S_RESP);
    assign io_addr     = addr_q;
    assign io_dout     = dout_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_atmega_io_bus_master.sv
// Directed bench for atmega_io_bus_master: three instances with RD_LATENCY 1, 0 and 3.
// Each instance has a peripheral model returning a programmed value sequence only in the
// cycle its read data is valid (0xEE otherwise), so any capture-timing slip shows up.
module tb_atmega_io_bus_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cmd_valid_w = 3'b000;
    logic [1:0] cmd_op   = 2'b00;
    logic [5:0] cmd_addr = 6'h00;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] cmd_mask = 8'h00;

    logic [2:0] cmd_ready_w, rsp_valid_w, rsp_to_w, io_wr_w, io_rd_w;
    logic [7:0] rsp_data_w [3];
    logic [5:0] io_addr_w  [3];
    logic [7:0] io_dout_w  [3];
    logic [7:0] io_din_w   [3];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    atmega_io_bus_master #(.BUS_ADDR_DATA_LEN(6), .RD_LATENCY(1), .POLL_INTERVAL(4), .POLL_TIMEOUT(4)) u_dut_l1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_w[0]), .cmd_ready(cmd_ready_w[0]),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]), .rsp_timeout(rsp_to_w[0]),
        .io_addr(io_addr_w[0]), .io_wr(io_wr_w[0]), .io_rd(io_rd_w[0]),
        .io_dout(io_dout_w[0]), .io_din(io_din_w[0]));

    atmega_io_bus_master #(.BUS_ADDR_DATA_LEN(6), .RD_LATENCY(0), .POLL_INTERVAL(4), .POLL_TIMEOUT(1024)) u_dut_l0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_w[1]), .cmd_ready(cmd_ready_w[1]),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]), .rsp_timeout(rsp_to_w[1]),
        .io_addr(io_addr_w[1]), .io_wr(io_wr_w[1]), .io_rd(io_rd_w[1]),
        .io_dout(io_dout_w[1]), .io_din(io_din_w[1]));

    atmega_io_bus_master #(.BUS_ADDR_DATA_LEN(6), .RD_LATENCY(3), .POLL_INTERVAL(4), .POLL_TIMEOUT(1024)) u_dut_l3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_w[2]), .cmd_ready(cmd_ready_w[2]),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid_w[2]), .rsp_data(rsp_data_w[2]), .rsp_timeout(rsp_to_w[2]),
        .io_addr(io_addr_w[2]), .io_wr(io_wr_w[2]), .io_rd(io_rd_w[2]),
        .io_dout(io_dout_w[2]), .io_din(io_din_w[2]));

    // ---------------- peripheral model ----------------
    logic [2:0] rd_d1 = 3'b000, rd_d2 = 3'b000, rd_d3 = 3'b000;
    int         rd_idx [3] = '{0, 0, 0};
    int         base   [3] = '{0, 0, 0};
    logic [7:0] seq    [3][8];

    function automatic int clampi(input int k);
        return (k < 0) ? 0 : ((k > 7) ? 7 : k);
    endfunction

    always @(posedge clk) begin
        rd_d1 <= io_rd_w;
        rd_d2 <= rd_d1;
        rd_d3 <= rd_d2;
        for (int i = 0; i < 3; i++)
            rd_idx[i] <= rd_idx[i] + ((io_rd_w[i] === 1'b1) ? 1 : 0);
    end

    always_comb begin
        io_din_w[0] = (rd_d1[0] === 1'b1)   ? seq[0][clampi(rd_idx[0] - base[0] - 1)] : 8'hEE;
        io_din_w[1] = (io_rd_w[1] === 1'b1) ? seq[1][clampi(rd_idx[1] - base[1])]     : 8'hEE;
        io_din_w[2] = (rd_d3[2] === 1'b1)   ? seq[2][clampi(rd_idx[2] - base[2] - 1)] : 8'hEE;
    end

    // ---------------- bus monitor ----------------
    int         wr_cnt  [3] = '{0, 0, 0};
    int         rd_cnt  [3] = '{0, 0, 0};
    int         rsp_cnt [3] = '{0, 0, 0};
    int         bad     [3] = '{0, 0, 0};
    int         wr_cyc  [3] = '{0, 0, 0};
    int         rsp_cyc [3] = '{0, 0, 0};
    int         rd_cyc  [3][16];
    logic [7:0] rsp_dat_s [3];
    logic       rsp_to_s  [3];
    logic [5:0] wr_addr_s [3];
    logic [5:0] rd_addr_s [3];
    logic [7:0] wr_dout_s [3];
    logic [2:0] prev_wr = 3'b000, prev_rd = 3'b000;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (io_wr_w[i] === 1'b1) begin
                wr_cnt[i]++;
                wr_cyc[i]    = cyc;
                wr_addr_s[i] = io_addr_w[i];
                wr_dout_s[i] = io_dout_w[i];
            end
            if (io_rd_w[i] === 1'b1) begin
                rd_cyc[i][rd_cnt[i] % 16] = cyc;
                rd_cnt[i]++;
                rd_addr_s[i] = io_addr_w[i];
            end
            if (rsp_valid_w[i] === 1'b1) begin
                rsp_cnt[i]++;
                rsp_cyc[i]   = cyc;
                rsp_dat_s[i] = rsp_data_w[i];
                rsp_to_s[i]  = rsp_to_w[i];
            end
            if ((io_wr_w[i] === 1'b1 && io_rd_w[i] === 1'b1) ||
                (io_wr_w[i] === 1'b1 && prev_wr[i]) ||
                (io_rd_w[i] === 1'b1 && prev_rd[i]))
                bad[i]++;
        end
        prev_wr = io_wr_w;
        prev_rd = io_rd_w;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_seq(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        seq[i][0] = a;
        seq[i][1] = b;
        for (int k = 2; k < 8; k++) seq[i][k] = c;
        base[i] = rd_idx[i];
    endtask

    // Presents a command and returns the cycle at whose closing edge it was accepted.
    task automatic issue(input int i, input logic [1:0] op, input logic [5:0] a,
                         input logic [7:0] d, input logic [7:0] m, input bit keep, output int acc);
        acc = -1;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
        cmd_valid_w[i] = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (cmd_ready_w[i] === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid_w[i] = 1'b0;
        end else begin
            @(negedge clk);
            if (!keep) cmd_valid_w[i] = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int i, input int n0, input int lim);
        bit seen = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            #1;
            if (rsp_cnt[i] > n0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("rsp_timeout_wait", 32'd0, 32'd1);
    endtask

    task automatic do_read(input int i, input logic [1:0] op, input logic [5:0] a,
                           input logic [7:0] val, input int lat, input string tag);
        int n_rd, n_rsp, acc;
        load_seq(i, val, val, val);
        n_rd = rd_cnt[i];
        n_rsp = rsp_cnt[i];
        issue(i, op, a, 8'h00, 8'h00, 1'b0, acc);
        wait_rsp(i, n_rsp, 40);
        idle(2);
        check({tag, "_rd_pulses"}, 32'(rd_cnt[i] - n_rd), 32'd1);
        check({tag, "_rd_cycle"},  32'(rd_cyc[i][n_rd % 16] - acc), 32'd1);
        check({tag, "_rd_addr"},   32'(rd_addr_s[i]), 32'(a));
        check({tag, "_rsp_delay"}, 32'(rsp_cyc[i] - rd_cyc[i][n_rd % 16]), 32'(lat));
        check({tag, "_rsp_data"},  32'(rsp_dat_s[i]), 32'(val));
        check({tag, "_rsp_to"},    32'(rsp_to_s[i]), 32'd0);
    endtask

    task automatic do_poll(input logic [7:0] d, input logic [7:0] m,
                           input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                           input int exp_n, input logic [7:0] exp_data, input logic exp_to,
                           input string tag);
        int n_rd, n_rsp, acc;
        load_seq(0, s0, s1, s2);
        n_rd = rd_cnt[0];
        n_rsp = rsp_cnt[0];
        issue(0, 2'b10, 6'h29, d, m, 1'b0, acc);
        wait_rsp(0, n_rsp, 200);
        idle(2);
        check({tag, "_rd_pulses"}, 32'(rd_cnt[0] - n_rd), 32'(exp_n));
        for (int k = 1; k < exp_n; k++)
            check({tag, "_rd_spacing"}, 32'(rd_cyc[0][(n_rd + k) % 16] - rd_cyc[0][(n_rd + k - 1) % 16]), 32'd7);
        check({tag, "_rsp_delay"}, 32'(rsp_cyc[0] - rd_cyc[0][(n_rd + exp_n - 1) % 16]), 32'd3);
        check({tag, "_rsp_data"},  32'(rsp_dat_s[0]), 32'(exp_data));
        check({tag, "_rsp_to"},    32'(rsp_to_s[0]), 32'(exp_to));
        check({tag, "_rsp_count"}, 32'(rsp_cnt[0] - n_rsp), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc, acc2, n_wr, n_rd, n_rsp;

        for (int i = 0; i < 3; i++) load_seq(i, 8'h00, 8'h00, 8'h00);

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready_w), 32'h7);
        check("rst_rsp_valid", 32'(rsp_valid_w), 32'h0);
        check("rst_io_wr",     32'(io_wr_w), 32'h0);
        check("rst_io_rd",     32'(io_rd_w), 32'h0);
        check("rst_rsp_to",    32'(rsp_to_w), 32'h0);
        check("rst_rsp_data",  32'(rsp_data_w[0]), 32'h0);
        check("rst_io_addr",   32'(io_addr_w[0]), 32'h0);
        check("rst_io_dout",   32'(io_dout_w[0]), 32'h0);

        // Write 0x0A to 0x32
        n_wr = wr_cnt[0];
        n_rsp = rsp_cnt[0];
        issue(0, 2'b00, 6'h32, 8'h0A, 8'h00, 1'b0, acc);
        wait_rsp(0, n_rsp, 20);
        idle(2);
        check("wr_pulses",    32'(wr_cnt[0] - n_wr), 32'd1);
        check("wr_cycle",     32'(wr_cyc[0] - acc), 32'd1);
        check("wr_addr",      32'(wr_addr_s[0]), 32'h32);
        check("wr_dout",      32'(wr_dout_s[0]), 32'h0A);
        check("wr_rsp_cycle", 32'(rsp_cyc[0] - acc), 32'd2);
        check("wr_rsp_data",  32'(rsp_dat_s[0]), 32'h00);
        check("wr_rsp_to",    32'(rsp_to_s[0]), 32'd0);
        check("wr_rsp_count", 32'(rsp_cnt[0] - n_rsp), 32'd1);
        check("wr_addr_hold", 32'(io_addr_w[0]), 32'h32);

        // Reads at three latencies, plus reserved op 11
        do_read(0, 2'b01, 6'h29, 8'h5C, 3, "rd_l1");
        do_read(1, 2'b01, 6'h29, 8'hA5, 2, "rd_l0");
        do_read(2, 2'b01, 6'h29, 8'h3C, 5, "rd_l3");
        do_read(0, 2'b11, 6'h1E, 8'h77, 3, "rd_op11");

        // Poll: match on third read, timeout after 4 reads, mask 0 matches at once
        do_poll(8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 3, 8'h03, 1'b0, "poll_match");
        do_poll(8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 4, 8'h00, 1'b1, "poll_tmo");
        do_poll(8'h55, 8'h00, 8'h12, 8'h12, 8'h12, 1, 8'h12, 1'b0, "poll_mask0");

        // Back-to-back: cmd_valid held high through a write then a read
        load_seq(0, 8'h6B, 8'h6B, 8'h6B);
        n_wr = wr_cnt[0];
        n_rd = rd_cnt[0];
        n_rsp = rsp_cnt[0];
        issue(0, 2'b00, 6'h10, 8'hC3, 8'h00, 1'b1, acc);
        issue(0, 2'b01, 6'h11, 8'h00, 8'h00, 1'b0, acc2);
        wait_rsp(0, n_rsp + 1, 40);
        idle(2);
        check("b2b_accept_gap", 32'(acc2 - acc), 32'd3);
        check("b2b_rsp_count",  32'(rsp_cnt[0] - n_rsp), 32'd2);
        check("b2b_wr_pulses",  32'(wr_cnt[0] - n_wr), 32'd1);
        check("b2b_rd_pulses",  32'(rd_cnt[0] - n_rd), 32'd1);
        check("b2b_wr_dout",    32'(wr_dout_s[0]), 32'hC3);
        check("b2b_rd_addr",    32'(rd_addr_s[0]), 32'h11);
        check("b2b_rsp_data",   32'(rsp_dat_s[0]), 32'h6B);

        // Reset during GAP of a poll that never matches
        load_seq(0, 8'h00, 8'h00, 8'h00);
        n_rd = rd_cnt[0];
        n_rsp = rsp_cnt[0];
        issue(0, 2'b10, 6'h29, 8'h01, 8'hFF, 1'b0, acc);
        // now in the RD cycle (acc+1); GAP starts at acc+4
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_io_rd",     32'(io_rd_w[0]), 32'd0);
        check("rstmid_rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
        rst = 1'b0;
        check("rstmid_cmd_ready", 32'(cmd_ready_w[0]), 32'd1);
        check("rstmid_rsp_data",  32'(rsp_data_w[0]), 32'h00);
        check("rstmid_io_addr",   32'(io_addr_w[0]), 32'h00);
        idle(30);
        #1;
        check("rstmid_rd_pulses", 32'(rd_cnt[0] - n_rd), 32'd1);
        check("rstmid_no_rsp",    32'(rsp_cnt[0] - n_rsp), 32'd0);

        n_wr = wr_cnt[0];
        n_rsp = rsp_cnt[0];
        issue(0, 2'b00, 6'h05, 8'h99, 8'h00, 1'b0, acc);
        wait_rsp(0, n_rsp, 20);
        idle(2);
        check("post_rst_wr_pulses", 32'(wr_cnt[0] - n_wr), 32'd1);
        check("post_rst_rsp_cycle", 32'(rsp_cyc[0] - acc), 32'd2);
        check("post_rst_wr_dout",   32'(wr_dout_s[0]), 32'h99);
        check("post_rst_wr_addr",   32'(wr_addr_s[0]), 32'h05);

        // Strobe rules over the whole run: never wr&rd together, never two cycles in a row
        check("strobe_rules", 32'(bad[0] + bad[1] + bad[2]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
